// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand select, RAW forwarding and load-use stall
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [15:0]   id_imm,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] alu_out,
    input  logic          exmem_regwrite,
    input  logic          exmem_memread,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    input  logic          flush,
    output logic [DW-1:0] ex_in1,
    output logic [DW-1:0] ex_in2,
    output logic [5:0]    ex_func1,
    output logic [5:0]    ex_func2,
    output logic          ex_aluop,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic [RW-1:0] ex_rd_dest,
    output logic [DW-1:0] ex_store_data,
    output logic          stall_id
);
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_LDRW = 6'h23;
    localparam logic [5:0] OP_STRW = 6'h2b, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_JUMP = 6'h02, OP_FLPT = 6'h11;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02;

    logic is_r, is_shift, is_imm, is_ld, is_st, is_br, known, use_rs, use_rt;
    logic haz, bubble;
    logic [RW-1:0] ld_ex, ld_mem, n_rd;
    logic [DW-1:0] rs_f, rt_f, imm_sx, n_in1, n_in2;

    // Youngest producer wins; the EX slot cannot forward a load since its data is not ready yet
    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] rf);
        if (src == '0) return '0;
        if (ex_valid && ex_regwrite && !ex_memread && ex_rd_dest == src) return alu_out;
        if (exmem_regwrite && !exmem_memread && exmem_rd == src) return exmem_result;
        if (memwb_regwrite && memwb_rd == src) return memwb_result;
        return rf;
    endfunction

    // Decode, forwarding, load-use hazard and next-state operand selection
    always_comb begin
        is_r     = id_opcode == OP_R;
        is_shift = is_r && (id_funct == F_SLL || id_funct == F_SRL);
        is_ld    = id_opcode == OP_LDRW;
        is_st    = id_opcode == OP_STRW;
        is_imm   = id_opcode == OP_ADDI || id_opcode == OP_SLTI || is_ld;
        is_br    = id_opcode == OP_BEQ || id_opcode == OP_BNE;
        known    = is_r || is_imm || is_st || is_br || id_opcode == OP_JUMP || id_opcode == OP_FLPT;
        use_rs   = (is_r && !is_shift) || is_imm || is_st || is_br;
        use_rt   = is_r || is_st || is_br;
        ld_ex    = (ex_valid && ex_memread) ? ex_rd_dest : '0;
        ld_mem   = exmem_memread ? exmem_rd : '0;
        haz      = (ld_ex != '0 && ((use_rs && id_rs == ld_ex) || (use_rt && id_rt == ld_ex))) ||
                   (ld_mem != '0 && ((use_rs && id_rs == ld_mem) || (use_rt && id_rt == ld_mem)));
        stall_id = reset && id_valid && haz && !flush;
        bubble   = flush || stall_id || !id_valid || !known;
        rs_f     = fwd(id_rs, id_rs_data);
        rt_f     = fwd(id_rt, id_rt_data);
        imm_sx   = {{(DW-16){id_imm[15]}}, id_imm};
        n_in1    = is_shift ? rt_f : (is_r || is_br || is_imm || is_st) ? rs_f : '0;
        n_in2    = is_shift ? {{(DW-5){1'b0}}, id_shamt} : (is_r || is_br) ? rt_f : (is_imm || is_st) ? imm_sx : '0;
        n_rd     = is_r ? id_rd : is_imm ? id_rt : '0;
    end

    // Capture the instruction, or a bubble on flush/stall/invalid/unknown opcode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_in1        <= '0;
            ex_in2        <= '0;
            ex_func1      <= '0;
            ex_func2      <= '0;
            ex_aluop      <= 1'b0;
            ex_valid      <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            ex_rd_dest    <= '0;
            ex_store_data <= '0;
        end else begin
            ex_in1        <= bubble ? '0 : n_in1;
            ex_in2        <= bubble ? '0 : n_in2;
            ex_func1      <= bubble ? '0 : id_funct;
            ex_func2      <= bubble ? '0 : id_opcode;
            ex_aluop      <= !bubble;
            ex_valid      <= !bubble;
            ex_regwrite   <= !bubble && (is_r || is_imm) && n_rd != '0;
            ex_memread    <= !bubble && is_ld;
            ex_memwrite   <= !bubble && is_st;
            ex_rd_dest    <= bubble ? '0 : n_rd;
            ex_store_data <= (bubble || !is_st) ? '0 : rt_f;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against an instruction-level reference model
module tb_id_ex_stage;
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_LDRW = 6'h23;
    localparam logic [5:0] OP_STRW = 6'h2b, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_JUMP = 6'h02, OP_FLPT = 6'h11;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] F_MUL = 6'h18, F_DIV = 6'h1a, F_SLT = 6'h2a;

    typedef struct packed {
        logic [31:0] in1, in2, sd;
        logic [5:0]  f1, f2;
        logic        aluop, valid, rw, mr, mw;
        logic [4:0]  rd;
    } ex_t;

    logic clk = 0;
    logic reset, id_valid, flush, exmem_regwrite, exmem_memread, memwb_regwrite;
    logic [5:0] id_opcode, id_funct;
    logic [4:0] id_rs, id_rt, id_rd, id_shamt, exmem_rd, memwb_rd;
    logic [15:0] id_imm;
    logic [31:0] id_rs_data, id_rt_data, alu_out, exmem_result, memwb_result;
    logic [31:0] ex_in1, ex_in2, ex_store_data;
    logic [5:0] ex_func1, ex_func2;
    logic ex_aluop, ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall_id;
    logic [4:0] ex_rd_dest;
    ex_t m, d;
    logic last_stall;
    int checks = 0, failures = 0;
    logic [5:0] ops [10] = '{OP_R, OP_ADDI, OP_SLTI, OP_LDRW, OP_STRW, OP_BEQ, OP_BNE, OP_JUMP, OP_FLPT, 6'h3f};
    logic [5:0] fns [7] = '{F_SLL, F_SRL, F_ADD, F_SUB, F_MUL, F_DIV, F_SLT};

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_imm(id_imm),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .alu_out(alu_out),
        .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result), .flush(flush), .ex_in1(ex_in1), .ex_in2(ex_in2),
        .ex_func1(ex_func1), .ex_func2(ex_func2), .ex_aluop(ex_aluop), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_rd_dest(ex_rd_dest), .ex_store_data(ex_store_data), .stall_id(stall_id)
    );

    assign d = {ex_in1, ex_in2, ex_store_data, ex_func1, ex_func2, ex_aluop, ex_valid,
                ex_regwrite, ex_memread, ex_memwrite, ex_rd_dest};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Value an instruction reading register s would see at this moment
    function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] rf);
        if (s == 0) return 32'd0;
        if (m.valid && m.rw && !m.mr && m.rd == s) return alu_out;
        if (exmem_regwrite && !exmem_memread && exmem_rd == s) return exmem_result;
        if (memwb_regwrite && memwb_rd == s) return memwb_result;
        return rf;
    endfunction

    // Registers the ID instruction reads (0 = slot unused)
    function automatic logic [9:0] reads();
        case (id_opcode)
            OP_R: return (id_funct == F_SLL || id_funct == F_SRL) ? {5'd0, id_rt} : {id_rs, id_rt};
            OP_ADDI, OP_SLTI, OP_LDRW: return {id_rs, 5'd0};
            OP_STRW, OP_BEQ, OP_BNE: return {id_rs, id_rt};
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic exp_stall();
        logic [9:0] r;
        logic [4:0] loads [2];
        logic haz;
        r = reads();
        loads[0] = (m.valid && m.mr) ? m.rd : 5'd0;
        loads[1] = exmem_memread ? exmem_rd : 5'd0;
        haz = 0;
        for (int j = 0; j < 2; j++)
            if (loads[j] != 0 && (loads[j] == r[9:5] || loads[j] == r[4:0])) haz = 1;
        return reset && id_valid && !flush && haz;
    endfunction

    function automatic ex_t predict(input logic st);
        ex_t n;
        logic [31:0] a, b, sx;
        n = '0;
        if (!reset || flush || st || !id_valid) return n;
        a = fwd(id_rs, id_rs_data);
        b = fwd(id_rt, id_rt_data);
        sx = {{16{id_imm[15]}}, id_imm};
        n.f1 = id_funct;
        n.f2 = id_opcode;
        n.aluop = 1;
        n.valid = 1;
        case (id_opcode)
            OP_R: begin
                if (id_funct == F_SLL || id_funct == F_SRL) begin
                    n.in1 = b;
                    n.in2 = {27'd0, id_shamt};
                end else begin
                    n.in1 = a;
                    n.in2 = b;
                end
                n.rd = id_rd;
            end
            OP_BEQ, OP_BNE: begin
                n.in1 = a;
                n.in2 = b;
            end
            OP_ADDI, OP_SLTI, OP_LDRW: begin
                n.in1 = a;
                n.in2 = sx;
                n.rd = id_rt;
                n.mr = id_opcode == OP_LDRW;
            end
            OP_STRW: begin
                n.in1 = a;
                n.in2 = sx;
                n.mw = 1;
                n.sd = b;
            end
            OP_JUMP, OP_FLPT: ;
            default: return '0;
        endcase
        n.rw = n.rd != 0;
        return n;
    endfunction

    task automatic step(input string tag);
        ex_t nxt;
        logic es;
        #2;
        es = exp_stall();
        last_stall = stall_id;
        chk({tag, ".stall"}, stall_id, es);
        nxt = predict(es);
        @(posedge clk);
        #1;
        m = nxt;
        chk({tag, ".ex"}, d, m);
    endtask

    task automatic clr();
        exmem_regwrite = 0; exmem_memread = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic inst(input logic [5:0] op, input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
        id_valid = 1; flush = 0; id_opcode = op; id_funct = f;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh; id_imm = imm;
        id_rs_data = $urandom; id_rt_data = $urandom; alu_out = $urandom;
    endtask

    initial begin
        m = '0;
        reset = 0;
        clr();
        inst(OP_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'hfffc);
        exmem_memread = 1; exmem_rd = 1;
        @(posedge clk);
        #1;
        step("rst0");
        step("rst1");
        chk("rst.stall", last_stall, 1'b0);
        reset = 1;
        clr();
        inst(OP_ADDI, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'hfffc);
        step("first");
        chk("first.in2", ex_in2, 32'hfffffffc);
        chk("first.rd", ex_rd_dest, 5'd2);
        chk("first.rw", ex_regwrite, 1'b1);
        inst(OP_ADDI, 6'd0, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5);
        step("w1");
        inst(OP_R, F_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        alu_out = 32'h55; exmem_regwrite = 1; exmem_rd = 1; exmem_result = 32'h99;
        step("exfwd");
        chk("exfwd.in1", ex_in1, 32'h55);
        clr();
        inst(OP_R, F_ADD, 5'd5, 5'd2, 5'd4, 5'd0, 16'd0);
        id_rt_data = 0; memwb_regwrite = 1; memwb_rd = 2; memwb_result = 32'h1234;
        step("wbfwd");
        chk("wbfwd.in2", ex_in2, 32'h1234);
        inst(OP_R, F_SUB, 5'd0, 5'd0, 5'd4, 5'd0, 16'd0);
        step("zero");
        chk("zero.ops", {ex_in1, ex_in2}, 64'd0);
        clr();
        inst(OP_LDRW, 6'd0, 5'd1, 5'd4, 5'd0, 5'd0, 16'd0);
        step("ld");
        inst(OP_R, F_ADD, 5'd4, 5'd4, 5'd5, 5'd0, 16'd0);
        step("lu1");
        chk("lu1.stall1", last_stall, 1'b1);
        chk("lu1.bubble", {ex_valid, ex_aluop}, 2'b00);
        exmem_memread = 1; exmem_regwrite = 1; exmem_rd = 4;
        step("lu2");
        chk("lu2.stall1", last_stall, 1'b1);
        chk("lu2.bubble", {ex_valid, ex_aluop}, 2'b00);
        clr();
        memwb_regwrite = 1; memwb_rd = 4; memwb_result = 32'habcd;
        step("lu3");
        chk("lu3.stall0", last_stall, 1'b0);
        chk("lu3.ops", {ex_in1, ex_in2}, {32'habcd, 32'habcd});
        clr();
        inst(OP_LDRW, 6'd0, 5'd1, 5'd6, 5'd0, 5'd0, 16'd4);
        step("ld2");
        inst(OP_R, F_ADD, 5'd6, 5'd0, 5'd7, 5'd0, 16'd0);
        flush = 1;
        step("fl");
        chk("fl.stall0", last_stall, 1'b0);
        chk("fl.bubble", ex_valid, 1'b0);
        inst(OP_ADDI, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 16'd1);
        step("afterfl");
        chk("afterfl.go", {ex_valid, ex_rd_dest}, {1'b1, 5'd8});
        clr();
        inst(OP_R, F_SLL, 5'd9, 5'd7, 5'd6, 5'd3, 16'd0);
        memwb_regwrite = 1; memwb_rd = 7; memwb_result = 32'h7777;
        step("sll");
        chk("sll.ops", {ex_in1, ex_in2}, {32'h7777, 32'd3});
        inst(OP_STRW, 6'd0, 5'd1, 5'd7, 5'd0, 5'd0, 16'd8);
        step("st");
        chk("st.ctl", {ex_memwrite, ex_regwrite}, 2'b10);
        chk("st.data", {ex_store_data, ex_in2}, {32'h7777, 32'd8});
        clr();
        inst(OP_LDRW, 6'd0, 5'd1, 5'd4, 5'd0, 5'd0, 16'd0);
        step("ms.ld");
        inst(OP_R, F_ADD, 5'd4, 5'd4, 5'd5, 5'd0, 16'd0);
        #2;
        chk("ms.stall1", stall_id, 1'b1);
        reset = 0;
        #1;
        m = '0;
        chk("ms.rst.ex", d, m);
        chk("ms.rst.stall", stall_id, 1'b0);
        @(posedge clk);
        #1;
        reset = 1;
        step("ms.rel");
        chk("ms.rel.stall0", last_stall, 1'b0);
        for (int i = 0; i < 400; i++) begin
            inst(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom));
            id_valid = $urandom_range(0, 7) != 0;
            flush = $urandom_range(0, 7) == 0;
            exmem_regwrite = 1'($urandom); exmem_memread = $urandom_range(0, 3) == 0;
            exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            reset = $urandom_range(0, 49) != 0;
            step("rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
